// File: rtl/slc3_pkg.sv
// Shared SLC-3 definitions: opcodes, branch-unit state encoding, offset sign extension.
// Pure declarations, no logic or latency.
// Imported by the branch unit and by any address path that needs sext9.
package slc3_pkg;

  localparam int SLC3_W = 16;

  localparam logic [3:0] OP_BR = 4'b0000;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CC,
    EVAL,
    ISSUE,
    DONE
  } br_state_t;

  // Sign-extend a 9-bit PC offset to the native datapath width.
  function automatic logic [SLC3_W-1:0] sext9(input logic [8:0] off);
    return {{(SLC3_W-9){off[8]}}, off};
  endfunction

endpackage

// File: rtl/br_target_adder.sv
// PC-relative target adder: target = base + sext9(offset), modulo 2^ADDR_W.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller registers the result.
module br_target_adder
  import slc3_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [8:0]        offset,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] off_ext;

  // The signed cast keeps the sign when ADDR_W is wider than the package width.
  assign off_ext = ADDR_W'($signed(sext9(offset)));
  assign target  = base + off_ext;

endmodule

// File: rtl/branch_unit.sv
// Branch resolution: waits out LD_CC, evaluates BEN and hands a taken target to the PC register.
// Latency: not taken done 2 cycles after start; taken done 3 cycles, plus one per cc_busy or stall cycle.
// Backpressure: pc_valid/pc_next hold in ISSUE until pc_ready; start outside IDLE is dropped.
module branch_unit
  import slc3_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] ir,
  input  logic [ADDR_W-1:0] pc,
  input  logic [2:0]        nzp,
  input  logic              cc_busy,
  input  logic              pc_ready,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] pc_next,
  output logic              ben,
  output logic              busy,
  output logic              done,
  input  logic              clear_count,
  output logic [CNT_W-1:0]  taken_count
);

  br_state_t         state_q, state_d;
  logic [ADDR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_next_q, pc_next_d;
  logic              ben_q, ben_d;
  logic              pc_valid_q, pc_valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] target;
  logic              eval_ben;
  logic              xfer;

  br_target_adder #(
    .ADDR_W (ADDR_W)
  ) u_target (
    .base   (pc_q),
    .offset (ir_q[8:0]),
    .target (target)
  );

  // BEN from the captured instruction and the condition codes seen during EVAL.
  assign eval_ben = (ir_q[15:12] == OP_BR) & (|(ir_q[11:9] & nzp));

  // Next-state, capture and counter logic; outputs are derived from the next state so they are registered.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    pc_next_d = pc_next_q;
    ben_d     = ben_q;
    xfer      = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          ir_d    = ir;
          pc_d    = pc;
          state_d = cc_busy ? WAIT_CC : EVAL;
        end
      end
      WAIT_CC: begin
        if (!cc_busy) state_d = EVAL;
      end
      EVAL: begin
        ben_d     = eval_ben;
        pc_next_d = target;
        state_d   = eval_ben ? ISSUE : DONE;
      end
      ISSUE: begin
        if (pc_ready) begin
          xfer    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Clear takes priority over a same-cycle increment; the count sticks at all-ones.
    if (clear_count) begin
      cnt_d = '0;
    end else if (xfer && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    pc_valid_d = (state_d == ISSUE);
    done_d     = (state_d == DONE);
    busy_d     = (state_d != IDLE);
  end

  // All state and registered outputs; async reset abandons any pending handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ir_q       <= '0;
      pc_q       <= '0;
      pc_next_q  <= '0;
      ben_q      <= 1'b0;
      pc_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      pc_next_q  <= pc_next_d;
      ben_q      <= ben_d;
      pc_valid_q <= pc_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_valid    = pc_valid_q;
  assign pc_next     = pc_next_q;
  assign ben         = ben_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign taken_count = cnt_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed plus randomized bench for branch_unit against a cycle-level reference model.
// Counter width is reduced so that saturation is reachable by plain traffic.
module tb_branch_unit;

  localparam int ADDR_W = 16;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] ir = '0;
  logic [ADDR_W-1:0] pc = '0;
  logic [2:0]        nzp = '0;
  logic              cc_busy = 1'b0;
  logic              pc_ready = 1'b0;
  logic              clear_count = 1'b0;
  logic              pc_valid;
  logic [ADDR_W-1:0] pc_next;
  logic              ben;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  taken_count;

  int vectors = 0;
  int miscompares = 0;
  int model_cnt = 0;

  branch_unit #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ir          (ir),
    .pc          (pc),
    .nzp         (nzp),
    .cc_busy     (cc_busy),
    .pc_ready    (pc_ready),
    .pc_valid    (pc_valid),
    .pc_next     (pc_next),
    .ben         (ben),
    .busy        (busy),
    .done        (done),
    .clear_count (clear_count),
    .taken_count (taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A BR is taken when any condition named in ir[11:9] (n,z,p) is currently set.
  function automatic bit ref_taken(input logic [15:0] i, input logic [2:0] cc);
    bit n_hit, z_hit, p_hit;
    if (i[15:12] != 4'b0000) return 1'b0;
    n_hit = i[11] && cc[2];
    z_hit = i[10] && cc[1];
    p_hit = i[9]  && cc[0];
    return n_hit || z_hit || p_hit;
  endfunction

  // Target = pc + signed 9-bit offset, wrapped modulo 65536.
  function automatic logic [15:0] ref_target(input logic [15:0] p, input logic [15:0] i);
    int off;
    int t;
    off = int'(i[8:0]);
    if (off >= 256) off = off - 512;
    t = int'(p) + off;
    if (t < 0) t = t + 65536;
    if (t >= 65536) t = t - 65536;
    return t[15:0];
  endfunction

  // One branch from IDLE: cc_busy held for n_busy cycles, ISSUE stalled s_stall cycles.
  task automatic run_br(input string tag, input logic [15:0] i_ir, input logic [15:0] i_pc,
                        input logic [2:0] nzp_pre, input logic [2:0] nzp_eval,
                        input int n_busy, input int s_stall, input bit clr_on_xfer);
    bit          taken;
    logic [15:0] tgt;
    int          ev, d, xf;
    bit          in_issue;
    taken = ref_taken(i_ir, nzp_eval);
    tgt   = ref_target(i_pc, i_ir);
    ev    = n_busy + 1;
    xf    = ev + 1 + s_stall;
    d     = taken ? ev + 2 + s_stall : ev + 1;
    if (taken) begin
      if (clr_on_xfer) model_cnt = 0;
      else if (model_cnt < CNT_MAX) model_cnt = model_cnt + 1;
    end
    for (int c = 0; c <= d; c++) begin
      @(posedge clk); #1;
      start = (c == 0) ? 1'b1 : 1'($urandom);
      if (c == 0) begin
        ir = i_ir;
        pc = i_pc;
      end else begin
        ir = 16'($urandom);
        pc = 16'($urandom);
      end
      if (c < n_busy)       cc_busy = 1'b1;
      else if (c == n_busy) cc_busy = 1'b0;
      else                  cc_busy = 1'($urandom);
      if (c < n_busy)   nzp = nzp_pre;
      else if (c <= ev) nzp = nzp_eval;
      else              nzp = 3'($urandom);
      in_issue    = taken && (c > ev) && (c <= xf);
      pc_ready    = in_issue ? (c == xf) : 1'($urandom);
      clear_count = taken && clr_on_xfer && (c == xf);
      @(negedge clk);
      chk({tag, "_busy"},  busy,     (c >= 1) && (c <= d));
      chk({tag, "_valid"}, pc_valid, in_issue);
      chk({tag, "_done"},  done,     c == d);
      if (in_issue) chk({tag, "_stable"}, pc_next, tgt);
      if (c == d) begin
        chk({tag, "_ben"},   ben,         taken);
        chk({tag, "_tgt"},   pc_next,     tgt);
        chk({tag, "_count"}, taken_count, model_cnt);
      end
    end
    @(posedge clk); #1;
    start       = 1'b0;
    cc_busy     = 1'b0;
    pc_ready    = 1'b0;
    clear_count = 1'b0;
  endtask

  initial begin
    logic [15:0] r_ir;
    int          k;

    // Reset state
    #1 reset = 1'b0;
    #2;
    chk("rst_valid", pc_valid, 0);
    chk("rst_ben",   ben, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_next",  pc_next, 0);
    chk("rst_count", taken_count, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Directed cases
    run_br("tp1_brnzp", 16'h0E05, 16'h3001, 3'b010, 3'b010, 0, 0, 1'b0);
    run_br("tp2_brn",   16'h0803, 16'h3001, 3'b001, 3'b001, 0, 0, 1'b0);
    run_br("tp3_stall", 16'h05FF, 16'h0000, 3'b010, 3'b010, 0, 4, 1'b0);
    run_br("tp4_wait",  16'h0802, 16'h2000, 3'b001, 3'b100, 2, 0, 1'b0);
    run_br("nop_cond",  16'h01FF, 16'h1234, 3'b111, 3'b111, 0, 0, 1'b0);
    run_br("nzp_zero",  16'h0E10, 16'h1234, 3'b000, 3'b000, 1, 0, 1'b0);
    run_br("not_br",    16'h1E05, 16'h1234, 3'b111, 3'b111, 0, 0, 1'b0);
    run_br("wrap_up",   16'h02FF, 16'hFFF0, 3'b001, 3'b001, 0, 1, 1'b0);

    // Asynchronous reset while waiting in ISSUE
    @(posedge clk); #1;
    start = 1'b1; ir = 16'h0E01; pc = 16'h1000; nzp = 3'b001; cc_busy = 1'b0; pc_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!pc_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid_pre_valid", pc_valid, 1);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_valid", pc_valid, 0);
    chk("rst_mid_ben",   ben, 0);
    chk("rst_mid_busy",  busy, 0);
    chk("rst_mid_count", taken_count, 0);
    chk("rst_mid_next",  pc_next, 0);
    #1 reset = 1'b1;
    model_cnt = 0;
    run_br("post_rst", 16'h0E03, 16'h4000, 3'b100, 3'b100, 0, 0, 1'b0);

    // Saturation of the taken counter, then clear coincident with a transfer
    for (int n = 0; n < CNT_MAX + 1; n++) begin
      r_ir = 16'($urandom);
      r_ir[15:9] = 7'b0000111;
      run_br("sat", r_ir, 16'($urandom), 3'b010, 3'b010, 0, 0, 1'b0);
    end
    chk("sat_hold", taken_count, CNT_MAX);
    run_br("clr_xfer", 16'h0E07, 16'h5000, 3'b001, 3'b001, 0, 2, 1'b1);
    run_br("after_clr", 16'h0E07, 16'h5000, 3'b001, 3'b001, 0, 0, 1'b0);

    // Standalone clear while idle
    clear_count = 1'b1;
    @(posedge clk); #1;
    clear_count = 1'b0;
    model_cnt = 0;
    chk("idle_clear", taken_count, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      r_ir = 16'($urandom);
      if ($urandom_range(3) != 0) r_ir[15:12] = 4'b0000;
      run_br("rand", r_ir, 16'($urandom), 3'($urandom), 3'($urandom),
             int'($urandom_range(2)), int'($urandom_range(3)), ($urandom_range(7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
Branch resolution stage for the SLC-3 datapath, directly downstream of the NZP condition-code register.
- On a start pulse from the control FSM, captures the instruction and incremented PC.
- Waits out any in-flight condition-code update, then evaluates BEN = |(IR[11:9] & NZP).
- For a taken branch, computes PC + SEXT(IR[8:0]) and delivers it to the PC register over a valid/ready handshake.
- Keeps a saturating taken-branch counter for debug.

Parameters:
ADDR_W, 16, width of PC, IR and branch target
CNT_W, 16, width of taken-branch counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  one-cycle request from control FSM; sampled only in IDLE
ir  in  ADDR_W  instruction word, valid in the start cycle
pc  in  ADDR_W  already-incremented PC, valid in the start cycle
nzp  in  3  current condition codes {n,z,p} from the NZP register output
cc_busy  in  1  LD_CC asserted this cycle; nzp not yet updated
pc_ready  in  1  PC register accepts pc_next this cycle
pc_valid  out  1  pc_next is valid and held stable
pc_next  out  ADDR_W  branch target
ben  out  1  registered branch-enable result of last evaluation
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the branch is resolved
clear_count  in  1  synchronous clear of taken_count
taken_count  out  CNT_W  number of completed taken branches, saturating

Behaviour:
- Reset (reset=0, async): state=IDLE; pc_valid, ben, done, busy = 0; pc_next = 0; taken_count = 0; captured ir_r/pc_r = 0. Reset mid-operation abandons any pending handshake immediately.
- States: IDLE, WAIT_CC, EVAL, ISSUE, DONE.
- IDLE:
  - On start=1, capture ir_r<=ir and pc_r<=pc.
  - If cc_busy=1, go to WAIT_CC; otherwise go to EVAL.
  - start in any other state is ignored (not queued).
- WAIT_CC: remain while cc_busy=1. Go to EVAL in the first cycle cc_busy=0; nzp is taken as settled in that cycle.
- EVAL:
  - ben <= (ir_r[15:12]==OP_BR) & |(ir_r[11:9] & nzp).
  - pc_next <= pc_r + sext9(ir_r[8:0]), truncated to ADDR_W. Wrap-around is modulo 2^16, no flag.
  - If the computed ben=1, go to ISSUE; otherwise go to DONE.
- ISSUE:
  - pc_valid=1 with pc_next stable.
  - Stay until pc_ready=1; the transfer occurs in that cycle.
  - On transfer, taken_count increments unless at all-ones, then go to DONE.
  - pc_ready outside ISSUE is ignored.
- DONE: done=1 for exactly one cycle, pc_valid=0, then go to IDLE.
- Special cases:
  - ir[11:9]=000: never taken (NOP).
  - ir[11:9]=111: always taken.
  - nzp=000 (post-reset) is never taken, except that it is still never taken with 111 since the AND is 0.
  - A non-BR opcode resolves as not taken.
- Latency from the start edge, cc_busy=0:
  - Not taken: EVAL at cycle 1, done at cycle 2.
  - Taken, pc_ready already high: ISSUE at cycle 2, done at cycle 3.
  - Each cycle in WAIT_CC or each stalled ISSUE cycle adds one.
- ben and pc_next hold their values until the next EVAL.
- clear_count=1 sets taken_count to 0 on the next edge. If it coincides with an increment, clear wins.

Decomposition:
- Shared package slc3_pkg holds:
  - OP_BR = 4'b0000
  - the state enum br_state_t {IDLE, WAIT_CC, EVAL, ISSUE, DONE}
  - function sext9 (9 to ADDR_W sign extension)
- One sub-module, br_target_adder: combinational pc_r + sext9(offset). It is reusable later by LD/ST/LEA address paths.
- The FSM, BEN register and counter live in branch_unit.

Test Plan:
1. ir=0x0E05 (BRnzp +5), pc=0x3001, nzp=010, cc_busy=0, pc_ready=1 -> ben=1; pc_valid in cycle 2 with pc_next=0x3006; done in cycle 3; taken_count=1.
2. ir=0x0803 (BRn +3), nzp=001 -> ben=0; pc_valid never asserts; done in cycle 2; taken_count unchanged.
3. ir=0x05FF (BRz -1), pc=0x0000, nzp=010, pc_ready held 0 for 4 cycles -> pc_next=0xFFFF stays stable with pc_valid=1 throughout the stall; count increments only on the ready cycle; done one cycle later.
4. start while cc_busy=1 for 2 cycles, nzp switching 001->100 when cc_busy drops, ir=0x0802 -> unit waits in WAIT_CC, evaluates with nzp=100, ben=1.
5. Assert reset=0 during ISSUE -> pc_valid, ben, busy and taken_count drop to 0 immediately, without a clock edge; a new start after release works normally.
6. Preload taken_count to all-ones (force or 2^CNT_W taken branches) plus one taken branch -> count stays all-ones. Then clear_count coincident with a transfer -> count=0.
